// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side push and decode-side pop handshakes of the instruction queue
interface fetch_queue_if #(
    parameter int AW = 2
);
    logic        Flush;
    logic        In_valid;
    logic        In_ready;
    logic [31:0] In_inst;
    logic [31:0] In_pc;
    logic        Out_valid;
    logic        Out_ready;
    logic [31:0] Out_inst;
    logic [31:0] Out_pc;
    logic [3:0]  Out_opcode;
    logic [AW:0] Count;
    logic        Overflow;

    modport master (
        output Flush, In_valid, In_inst, In_pc, Out_ready,
        input  In_ready, Out_valid, Out_inst, Out_pc, Out_opcode, Count, Overflow
    );

    modport slave (
        input  Flush, In_valid, In_inst, In_pc, Out_ready,
        output In_ready, Out_valid, Out_inst, Out_pc, Out_opcode, Count, Overflow
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: in-order fall-through instruction buffer between fetch and decode, flushable on redirect
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input logic        Clk,
    input logic        Rst,
    fetch_queue_if.slave bus
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          push, pop;
    logic [63:0]   head;
    assign bus.In_ready   = cnt_q != FULL;
    assign bus.Out_valid  = cnt_q != '0;
    assign head           = bus.Out_valid ? mem_q[rp_q] : 64'd0;
    assign bus.Out_inst   = head[63:32];
    assign bus.Out_pc     = head[31:0];
    assign bus.Out_opcode = head[63:60];
    assign bus.Count      = cnt_q;
    assign bus.Overflow   = ovf_q;
    always_comb begin
        push  = bus.In_valid & bus.In_ready & ~bus.Flush;
        pop   = bus.Out_valid & bus.Out_ready & ~bus.Flush;
        mem_d = mem_q;
        if (push) mem_d[wp_q] = {bus.In_inst, bus.In_pc};
        wp_d  = bus.Flush ? '0 : wp_q + AW'(push);
        rp_d  = bus.Flush ? '0 : rp_q + AW'(pop);
        cnt_d = bus.Flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        ovf_d = ovf_q | (bus.In_valid & ~bus.In_ready);
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end
    always_ff @(posedge Clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fill/drain, streaming wrap, full+pop, flush and reset
module tb_fetch_queue;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    fetch_queue_if #(.AW(2)) bus ();
    fetch_queue #(.DEPTH(4), .AW(2)) dut (.Clk(clk), .Rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        bus.In_valid = v;
        bus.In_inst  = inst;
        bus.In_pc    = pc;
    endtask
    initial begin
        rst = 1'b1;
        bus.Flush = 1'b0;
        bus.Out_ready = 1'b0;
        drive(1'b1, 32'hDEADBEEF, 32'h7);
        step();
        step();
        check("rst_count", 64'(bus.Count), 0);
        check("rst_out_valid", 64'(bus.Out_valid), 0);
        check("rst_in_ready", 64'(bus.In_ready), 1);
        check("rst_out_inst", 64'(bus.Out_inst), 0);
        check("rst_out_pc", 64'(bus.Out_pc), 0);
        check("rst_opcode", 64'(bus.Out_opcode), 0);
        check("rst_overflow", 64'(bus.Overflow), 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ((i + 1) << 28) | (i + 1), i);
            if (i == 0) check("empty_push_out_valid", 64'(bus.Out_valid), 0);
            step();
        end
        drive(1'b0, 0, 0);
        check("fill_count", 64'(bus.Count), 4);
        check("fill_in_ready", 64'(bus.In_ready), 0);
        check("fill_opcode", 64'(bus.Out_opcode), 1);
        check("fill_overflow", 64'(bus.Overflow), 0);
        bus.Out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_inst", 64'(bus.Out_inst), ((i + 1) << 28) | (i + 1));
            check("drain_pc", 64'(bus.Out_pc), i);
            step();
        end
        check("drain_out_valid", 64'(bus.Out_valid), 0);
        check("drain_count", 64'(bus.Count), 0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'hA000_0000 + i, i);
            step();
            check("stream_valid", 64'(bus.Out_valid), 1);
            check("stream_pc", 64'(bus.Out_pc), i);
            check("stream_inst", 64'(bus.Out_inst), 32'hA000_0000 + i);
            check("stream_count", 64'(bus.Count), 1);
        end
        drive(1'b0, 0, 0);
        step();
        check("stream_end_count", 64'(bus.Count), 0);
        bus.Out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hB000_0000 + i, 32'h100 + i);
            step();
        end
        drive(1'b1, 32'hC000_0000, 32'h200);
        bus.Out_ready = 1'b1;
        check("full_in_ready", 64'(bus.In_ready), 0);
        step();
        check("full_pop_count", 64'(bus.Count), 3);
        check("full_overflow", 64'(bus.Overflow), 1);
        check("full_pop_head", 64'(bus.Out_pc), 32'h101);
        bus.Out_ready = 1'b0;
        check("after_full_in_ready", 64'(bus.In_ready), 1);
        step();
        drive(1'b0, 0, 0);
        check("after_full_count", 64'(bus.Count), 4);
        bus.Out_ready = 1'b1;
        check("order_0", 64'(bus.Out_pc), 32'h101);
        step();
        check("order_1", 64'(bus.Out_pc), 32'h102);
        step();
        check("order_2", 64'(bus.Out_pc), 32'h103);
        step();
        check("order_3", 64'(bus.Out_pc), 32'h200);
        check("order_3_inst", 64'(bus.Out_inst), 32'hC000_0000);
        step();
        check("order_empty", 64'(bus.Out_valid), 0);
        bus.Out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h1000_0000 + i, 32'h10 + i);
            step();
        end
        check("pre_flush_count", 64'(bus.Count), 3);
        bus.Flush = 1'b1;
        bus.Out_ready = 1'b1;
        drive(1'b1, 32'h1000_0013, 32'h13);
        step();
        bus.Flush = 1'b0;
        bus.Out_ready = 1'b0;
        drive(1'b0, 0, 0);
        check("flush_count", 64'(bus.Count), 0);
        check("flush_out_valid", 64'(bus.Out_valid), 0);
        check("flush_in_ready", 64'(bus.In_ready), 1);
        check("flush_out_pc", 64'(bus.Out_pc), 0);
        check("flush_keeps_overflow", 64'(bus.Overflow), 1);
        drive(1'b1, 32'h5000_0020, 32'h20);
        step();
        drive(1'b1, 32'h6000_0021, 32'h21);
        check("post_flush_pc", 64'(bus.Out_pc), 32'h20);
        check("post_flush_opcode", 64'(bus.Out_opcode), 5);
        check("post_flush_valid", 64'(bus.Out_valid), 1);
        step();
        drive(1'b0, 0, 0);
        check("pre_rst_count", 64'(bus.Count), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_overflow", 64'(bus.Overflow), 0);
        check("rst2_count", 64'(bus.Count), 0);
        check("rst2_out_valid", 64'(bus.Out_valid), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
